// File: rtl/pixel_readout_pkg.sv
// Sensor array geometry and shared types for the row readout path.
`timescale 1ns/1ps
package PixelSensorConfig;
  localparam int PIXEL_ARRAY_WIDTH  = 4;
  localparam int PIXEL_ARRAY_HEIGHT = 4;
  localparam int PIXEL_BITS         = 8;
  localparam int ROW_IDX_BITS       = $clog2(PIXEL_ARRAY_HEIGHT);
  localparam int COL_IDX_BITS       = $clog2(PIXEL_ARRAY_WIDTH);

  typedef logic [PIXEL_BITS-1:0] pixel_t;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } readout_state_e;
endpackage

// File: rtl/pixel_readout_row_index_encoder.sv
// One-hot to binary encoder; valid is high only when exactly one bit is set.
`timescale 1ns/1ps
module row_index_encoder
  import PixelSensorConfig::*;
#(
  parameter int N     = PIXEL_ARRAY_HEIGHT,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     onehot,
  output logic [IDX_W-1:0] index,
  output logic             valid
);
  logic seen_s;
  logic multi_s;

  // OR-reduce the set bit positions while tracking zero/many set bits
  always_comb begin
    index   = '0;
    seen_s  = 1'b0;
    multi_s = 1'b0;
    for (int i = 0; i < N; i++) begin
      multi_s = multi_s | (seen_s & onehot[i]);
      seen_s  = seen_s | onehot[i];
      index   = index | (onehot[i] ? IDX_W'(i) : '0);
    end
    valid = seen_s & ~multi_s;
  end
endmodule

// File: rtl/pixel_readout.sv
// Double-buffered row capture and one-pixel-per-beat serialiser.
// Optional Gray->binary pixel decode: define PIXEL_READOUT_GRAY_DECODE_EN.
`timescale 1ns/1ps
module pixel_readout
  import PixelSensorConfig::*;
#(
  parameter int WIDTH  = PIXEL_ARRAY_WIDTH,
  parameter int HEIGHT = PIXEL_ARRAY_HEIGHT,
  parameter int BITS   = PIXEL_BITS
) (
  input  logic                      CLK,
  input  logic                      RESET_N,
  input  logic                      NEW_ROW,
  input  logic [HEIGHT-1:0]         ROW_SELECT,
  input  logic [WIDTH*BITS-1:0]     PIXEL_DATA,
  output logic [BITS-1:0]           OUT_DATA,
  output logic [$clog2(HEIGHT)-1:0] OUT_ROW,
  output logic [$clog2(WIDTH)-1:0]  OUT_COL,
  output logic                      OUT_FRAME_END,
  output logic                      OUT_VALID,
  input  logic                      OUT_READY,
  output logic                      OVERFLOW,
  output logic                      ROW_ERROR
);
  localparam int ROW_W = $clog2(HEIGHT);
  localparam int COL_W = $clog2(WIDTH);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(HEIGHT - 1);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(WIDTH - 1);

  readout_state_e        state_r, state_nxt_s;
  logic [WIDTH*BITS-1:0] cap_data_r, sh_data_r;
  logic [ROW_W-1:0]      cap_row_r, sel_idx_s, load_row_s;
  logic [COL_W-1:0]      next_col_s, load_col_s;
  logic [BITS-1:0]       raw_pix_s, dec_pix_s;
  logic cap_full_r, sel_valid_s, accept_s, last_beat_s, xfer_s, capture_s, load_s;

  row_index_encoder #(.N(HEIGHT), .IDX_W(ROW_W)) u_sel_enc (
    .onehot (ROW_SELECT),
    .index  (sel_idx_s),
    .valid  (sel_valid_s)
  );

  assign accept_s    = OUT_VALID & OUT_READY;
  assign last_beat_s = accept_s & (OUT_COL == LAST_COL);
  assign xfer_s      = cap_full_r & ((state_r == IDLE) | last_beat_s);
  assign capture_s   = NEW_ROW & sel_valid_s & (~cap_full_r | xfer_s);
  assign next_col_s  = OUT_COL + COL_W'(1);

`ifdef PIXEL_READOUT_GRAY_DECODE_EN
  function automatic logic [BITS-1:0] gray_to_bin(input logic [BITS-1:0] g);
    logic [BITS-1:0] b;
    b[BITS-1] = g[BITS-1];
    for (int i = BITS - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction
  assign dec_pix_s = gray_to_bin(raw_pix_s);
`else
  assign dec_pix_s = raw_pix_s;
`endif

  // Next-state: SHIFT while a row is being emitted, IDLE once drained
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE:    if (cap_full_r) state_nxt_s = SHIFT; else state_nxt_s = IDLE;
      SHIFT:   if (last_beat_s && !cap_full_r) state_nxt_s = IDLE; else state_nxt_s = SHIFT;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Select the next beat: first pixel of a freshly transferred row or the next column
  always_comb begin
    load_s     = 1'b0;
    load_row_s = OUT_ROW;
    load_col_s = next_col_s;
    raw_pix_s  = sh_data_r[BITS*int'(next_col_s) +: BITS];
    if (xfer_s) begin
      load_s     = 1'b1;
      load_row_s = cap_row_r;
      load_col_s = '0;
      raw_pix_s  = cap_data_r[BITS-1:0];
    end else if (accept_s && !last_beat_s) begin
      load_s = 1'b1;
    end else begin
      load_s = 1'b0;
    end
  end

  // FSM state register
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state_r <= IDLE;
    else          state_r <= state_nxt_s;
  end

  // Capture buffer and sticky error flags; a bad select wins over overflow
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      cap_data_r <= '0;
      cap_row_r  <= '0;
      cap_full_r <= 1'b0;
      OVERFLOW   <= 1'b0;
      ROW_ERROR  <= 1'b0;
    end else begin
      if (capture_s) begin
        cap_data_r <= PIXEL_DATA;
        cap_row_r  <= sel_idx_s;
        cap_full_r <= 1'b1;
      end else if (xfer_s) begin
        cap_full_r <= 1'b0;
      end
      if (NEW_ROW && !sel_valid_s) ROW_ERROR <= 1'b1;
      if (NEW_ROW && sel_valid_s && cap_full_r && !xfer_s) OVERFLOW <= 1'b1;
    end
  end

  // Shift buffer and output beat registers; OUT_COL doubles as the column counter
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      sh_data_r     <= '0;
      OUT_DATA      <= '0;
      OUT_ROW       <= '0;
      OUT_COL       <= '0;
      OUT_FRAME_END <= 1'b0;
      OUT_VALID     <= 1'b0;
    end else if (load_s) begin
      if (xfer_s) sh_data_r <= cap_data_r;
      OUT_DATA      <= dec_pix_s;
      OUT_ROW       <= load_row_s;
      OUT_COL       <= load_col_s;
      OUT_FRAME_END <= (load_row_s == LAST_ROW) && (load_col_s == LAST_COL);
      OUT_VALID     <= 1'b1;
    end else if (last_beat_s) begin
      OUT_VALID     <= 1'b0;
      OUT_FRAME_END <= 1'b0;
    end
  end
endmodule

// File: tb/tb_pixel_readout.sv
// Directed bench for pixel_readout (WIDTH=4, HEIGHT=4, BITS=8).
`timescale 1ns/1ps
module tb_pixel_readout;
  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        NEW_ROW = 1'b0;
  logic [3:0]  ROW_SELECT = 4'b0000;
  logic [31:0] PIXEL_DATA = 32'h0;
  logic [7:0]  OUT_DATA;
  logic [1:0]  OUT_ROW, OUT_COL;
  logic        OUT_FRAME_END, OUT_VALID, OVERFLOW, ROW_ERROR;
  logic        OUT_READY = 1'b1;

  int total_cnt = 0;
  int bad_cnt   = 0;

  typedef struct { int row; int col; int data; int fe; } beat_t;
  beat_t beat_q[$];
  logic        hold_v = 1'b0;
  logic [12:0] hold_val = 13'h0;

  pixel_readout #(.WIDTH(4), .HEIGHT(4), .BITS(8)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .NEW_ROW(NEW_ROW), .ROW_SELECT(ROW_SELECT),
    .PIXEL_DATA(PIXEL_DATA), .OUT_DATA(OUT_DATA), .OUT_ROW(OUT_ROW), .OUT_COL(OUT_COL),
    .OUT_FRAME_END(OUT_FRAME_END), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .OVERFLOW(OVERFLOW), .ROW_ERROR(ROW_ERROR)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] exp_pix(input logic [7:0] g);
`ifdef PIXEL_READOUT_GRAY_DECODE_EN
    logic [7:0] b;
    b[7] = g[7];
    for (int i = 6; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
`else
    return g;
`endif
  endfunction

  function automatic logic [31:0] row_word(input int r);
    logic [31:0] w;
    for (int c = 0; c < 4; c++) w[c*8 +: 8] = 8'(128 + 16 * r + c);
    return w;
  endfunction

  // Beat collector plus stall-stability check, sampled mid-cycle
  always @(negedge CLK) begin
    if (!RESET_N) begin
      hold_v <= 1'b0;
    end else begin
      if (hold_v) check("hold", {19'h0, OUT_VALID, OUT_ROW, OUT_COL, OUT_DATA}, {19'h0, hold_val});
      if (OUT_VALID && OUT_READY)
        beat_q.push_back('{row: int'(OUT_ROW), col: int'(OUT_COL), data: int'(OUT_DATA), fe: int'(OUT_FRAME_END)});
      hold_v   <= OUT_VALID && !OUT_READY;
      hold_val <= {OUT_VALID, OUT_ROW, OUT_COL, OUT_DATA};
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge CLK); #1; end
  endtask

  task automatic strobe(input logic [3:0] sel, input logic [31:0] data);
    NEW_ROW = 1'b1; ROW_SELECT = sel; PIXEL_DATA = data;
    @(posedge CLK); #1;
    NEW_ROW = 1'b0; ROW_SELECT = 4'b0000;
  endtask

  task automatic do_reset();
    RESET_N = 1'b0;
    idle(2);
    RESET_N = 1'b1;
    idle(1);
  endtask

  task automatic check_row(input int base, input int row, input logic [31:0] word);
    for (int c = 0; c < 4; c++) begin
      if (base + c < beat_q.size()) begin
        check("beat_row",  beat_q[base+c].row,  row);
        check("beat_col",  beat_q[base+c].col,  c);
        check("beat_data", beat_q[base+c].data, exp_pix(word[c*8 +: 8]));
        check("beat_fe",   beat_q[base+c].fe,   (row == 3 && c == 3) ? 1 : 0);
      end else begin
        check("beat_missing", base + c, beat_q.size());
      end
    end
  endtask

  initial begin
    // reset values
    #1;
    check("rst_valid", OUT_VALID, 1'b0);
    check("rst_data",  OUT_DATA,  8'h00);
    check("rst_flags", {OVERFLOW, ROW_ERROR}, 2'b00);
    idle(2);
    RESET_N = 1'b1;
    idle(1);

    // single row, latency and order
    beat_q.delete();
    strobe(4'b0100, 32'h44332211);
    check("lat_valid_t", OUT_VALID, 1'b0);
    idle(1);
    check("lat_valid_t1", OUT_VALID, 1'b1);
    check("lat_col0", OUT_COL, 2'd0);
    check("lat_row", OUT_ROW, 2'd2);
    check("lat_data", OUT_DATA, exp_pix(8'h11));
    idle(6);
    check("row1_count", beat_q.size(), 4);
    check_row(0, 2, 32'h44332211);

    // full frame, one strobe every 5 cycles
    beat_q.delete();
    for (int r = 0; r < 4; r++) begin
      strobe(4'(1 << r), row_word(r));
      idle(4);
    end
    idle(6);
    check("frame_count", beat_q.size(), 16);
    for (int r = 0; r < 4; r++) check_row(4 * r, r, row_word(r));
    check("frame_flags", {OVERFLOW, ROW_ERROR}, 2'b00);

    // stalled consumer: third row is dropped
    beat_q.delete();
    OUT_READY = 1'b0;
    for (int r = 0; r < 3; r++) begin
      strobe(4'(1 << r), row_word(r + 4));
      idle(1);
    end
    idle(3);
    check("ovf_flag", OVERFLOW, 1'b1);
    check("ovf_rowerr", ROW_ERROR, 1'b0);
    check("ovf_nobeats", beat_q.size(), 0);
    OUT_READY = 1'b1;
    idle(14);
    check("ovf_count", beat_q.size(), 8);
    check_row(0, 0, row_word(4));
    check_row(4, 1, row_word(5));

    // illegal selects
    do_reset();
    beat_q.delete();
    strobe(4'b0000, 32'hDEADBEEF);
    idle(2);
    strobe(4'b0110, 32'hCAFEF00D);
    idle(6);
    check("err_nobeats", beat_q.size(), 0);
    check("err_flag", ROW_ERROR, 1'b1);
    check("err_ovf", OVERFLOW, 1'b0);
    check("err_valid", OUT_VALID, 1'b0);

    // toggling ready
    beat_q.delete();
    NEW_ROW = 1'b1; ROW_SELECT = 4'b0010; PIXEL_DATA = 32'h5A4B3C2D;
    for (int i = 0; i < 20; i++) begin
      @(posedge CLK); #1;
      NEW_ROW = 1'b0; ROW_SELECT = 4'b0000;
      OUT_READY = (i % 2 == 1);
    end
    OUT_READY = 1'b1;
    idle(4);
    check("tog_count", beat_q.size(), 4);
    check_row(0, 1, 32'h5A4B3C2D);

    // reset in the middle of a row
    beat_q.delete();
    strobe(4'b0001, row_word(7));
    idle(3);
    check("mid_col2", OUT_COL, 2'd2);
    RESET_N = 1'b0;
    #1;
    check("mid_valid", OUT_VALID, 1'b0);
    check("mid_outs", {OUT_DATA, OUT_ROW, OUT_COL, OUT_FRAME_END}, 13'h0);
    check("mid_flags", {OVERFLOW, ROW_ERROR}, 2'b00);
    idle(2);
    RESET_N = 1'b1;
    idle(1);
    beat_q.delete();
    strobe(4'b1000, row_word(9));
    idle(8);
    check("post_rst_count", beat_q.size(), 4);
    check_row(0, 3, row_word(9));

`ifdef PIXEL_READOUT_GRAY_DECODE_EN
    strobe(4'b0001, 32'h0000000C);
    idle(1);
    check("gray_0c", OUT_DATA, 8'h08);
    idle(6);
`endif

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end
endmodule
